// File: rtl/crc32_if.sv
// Word-wide CRC-32 update port: data word, per-lane valid mask, running state in, registered state out.
interface crc32_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CRC_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0]   i_data;
    logic [CRC_WIDTH-1:0]    i_crc_state;
    logic [DATA_WIDTH/8-1:0] i_data_valid;
    logic [DATA_WIDTH-1:0]   o_crc;

    // No handshake: the slave accepts a word every cycle; a zero mask means "no data this cycle".
    modport master (
        output i_data,
        output i_crc_state,
        output i_data_valid,
        input  o_crc
    );

    modport slave (
        input  i_data,
        input  i_crc_state,
        input  i_data_valid,
        output o_crc
    );
endinterface

// File: rtl/crc32.sv
// IEEE 802.3 CRC-32 (reflected 0xEDB88320), 4 byte lanes per cycle, raw state out with one cycle latency.
// Full words use slicing-by-4; partial words fall back to a byte-serial Sarwate chain.
module crc32 #(
    parameter int DATA_WIDTH = 32,
    parameter int CRC_WIDTH  = 32
) (
    input  logic   i_clk,
    input  logic   i_reset,
    crc32_if.slave bus
);
    localparam logic [31:0] POLY = 32'hEDB88320;

    function automatic logic [31:0] sarwate_entry(input logic [7:0] idx);
        logic [31:0] c;
        c = {24'd0, idx};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Tn[i] advances T0[i] through n further zero bytes.
    function automatic logic [31:0] table_entry(input int n, input logic [7:0] idx);
        logic [31:0] v;
        v = sarwate_entry(idx);
        for (int k = 1; k <= n; k++) begin
            v = (v >> 8) ^ sarwate_entry(v[7:0]);
        end
        return v;
    endfunction

    logic [31:0] t0 [256];
    logic [31:0] t1 [256];
    logic [31:0] t2 [256];
    logic [31:0] t3 [256];

    for (genvar i = 0; i < 256; i++) begin : g_rom
        assign t0[i] = table_entry(0, 8'(i));
        assign t1[i] = table_entry(1, 8'(i));
        assign t2[i] = table_entry(2, 8'(i));
        assign t3[i] = table_entry(3, 8'(i));
    end

    logic [CRC_WIDTH-1:0]  crc_q;
    logic [CRC_WIDTH-1:0]  crc_d;
    logic [CRC_WIDTH-1:0]  x;
    logic [CRC_WIDTH-1:0]  sliced;
    logic [CRC_WIDTH-1:0]  ser1, ser2, ser3;
    logic [CRC_WIDTH-1:0]  next_crc;
    logic [DATA_WIDTH-1:0] data;
    logic [2:0]            n_lanes;

    assign data = bus.i_data;
    assign x    = bus.i_crc_state ^ data;

    assign sliced = t3[x[7:0]] ^ t2[x[15:8]] ^ t1[x[23:16]] ^ t0[x[31:24]];

    assign ser1 = (bus.i_crc_state >> 8) ^ t0[bus.i_crc_state[7:0] ^ data[7:0]];
    assign ser2 = (ser1 >> 8) ^ t0[ser1[7:0] ^ data[15:8]];
    assign ser3 = (ser2 >> 8) ^ t0[ser2[7:0] ^ data[23:16]];

    // Only the contiguous run of set bits from lane 0 counts; anything above the first hole is ignored.
    always_comb begin
        n_lanes = 3'd0;
        if (bus.i_data_valid[0]) begin
            n_lanes = 3'd1;
            if (bus.i_data_valid[1]) begin
                n_lanes = 3'd2;
                if (bus.i_data_valid[2]) begin
                    n_lanes = 3'd3;
                    if (bus.i_data_valid[3]) n_lanes = 3'd4;
                end
            end
        end
    end

    always_comb begin
        next_crc = bus.i_crc_state;
        case (n_lanes)
            3'd1:    next_crc = ser1;
            3'd2:    next_crc = ser2;
            3'd3:    next_crc = ser3;
            3'd4:    next_crc = sliced;
            default: next_crc = bus.i_crc_state;
        endcase
    end

    always_comb begin
        crc_d = crc_q;
        if (|bus.i_data_valid) crc_d = next_crc;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) crc_q <= '1;
        else         crc_q <= crc_d;
    end

    assign bus.o_crc = crc_q;
endmodule

// File: tb/tb_crc32.sv
// Scoreboard bench for crc32: driver pushes the expected o_crc per cycle, a monitor pops and compares after each edge.
module tb_crc32;
  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] W0 = 32'h34333231;
  localparam logic [31:0] W1 = 32'h38373635;
  localparam logic [31:0] W2 = 32'h00000039;

  logic i_clk = 1'b0;
  logic i_reset;

  crc32_if #(.DATA_WIDTH(32), .CRC_WIDTH(32)) bus_if ();

  crc32 #(.DATA_WIDTH(32), .CRC_WIDTH(32)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus_if)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model;

  // Bitwise reference, independent of any table.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] st, input logic [31:0] d,
                                             input logic [3:0] m);
    logic [31:0] c;
    c = st;
    for (int k = 0; k < 4; k++) begin
      if (!m[k]) break;
      c = crc_byte(c, d[8*k +: 8]);
    end
    return c;
  endfunction

  task automatic push_exp(input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input string nm);
    @(negedge i_clk);
    i_reset             = 1'b1;
    bus_if.i_data       = $urandom;
    bus_if.i_crc_state  = $urandom;
    bus_if.i_data_valid = 4'b1111;
    model = 32'hFFFFFFFF;
    push_exp(32'hFFFFFFFF, nm);
  endtask

  task automatic feed(input logic [31:0] st, input logic [31:0] d, input logic [3:0] m,
                      input string nm);
    @(negedge i_clk);
    i_reset             = 1'b0;
    bus_if.i_data       = d;
    bus_if.i_crc_state  = st;
    bus_if.i_data_valid = m;
    if (m != 4'b0000) model = model_word(st, d, m);
    push_exp(model, nm);
  endtask

  // Idle cycle with junk on data/state, checking o_crc against a hand-computed constant.
  task automatic check_const(input logic [31:0] c, input string nm);
    @(negedge i_clk);
    i_reset             = 1'b0;
    bus_if.i_data       = $urandom;
    bus_if.i_crc_state  = $urandom;
    bus_if.i_data_valid = 4'b0000;
    push_exp(c, nm);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) feed($urandom, $urandom, 4'b0000, "hold");
  endtask

  always begin
    @(posedge i_clk);
    #1;
    if (exp_q.size() != 0) begin
      logic [31:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (bus_if.o_crc !== e) begin
        errors++;
        $display("FAIL %s: o_crc got %08h expected %08h", nm, bus_if.o_crc, e);
      end
    end
  end

  initial begin
    i_reset             = 1'b1;
    bus_if.i_data       = '0;
    bus_if.i_crc_state  = '0;
    bus_if.i_data_valid = '0;
    model               = 32'hFFFFFFFF;

    do_reset("reset_0");
    do_reset("reset_1");

    feed(model, 32'h00000000, 4'b1111, "zero_word");
    check_const(32'hDEBB20E3, "zero_word_const");

    do_reset("reset_a");
    feed(model, 32'h00000000, 4'b0001, "zero_byte");
    check_const(32'h2DFD1072, "zero_byte_const");

    do_reset("reset_b");
    feed(model, W0, 4'b1111, "check_w0");
    feed(model, W1, 4'b1111, "check_w1");
    feed(model, W2, 4'b0001, "check_w2");
    check_const(32'h340BC6D9, "check_123456789");
    check_const(~32'hCBF43926, "check_fcs");

    do_reset("reset_c");
    feed(model, W0, 4'b1111, "gap_w0");
    gap(3);
    feed(model, W1, 4'b1111, "gap_w1");
    gap(2);
    feed(model, W2, 4'b0001, "gap_w2");
    check_const(32'h340BC6D9, "gap_123456789");

    do_reset("reset_d");
    feed(model, W0, 4'b1111, "mid_w0");
    feed(model, W1, 4'b1111, "mid_w1");
    do_reset("mid_reset");
    feed(model, W0, 4'b1111, "restart_w0");
    feed(model, W1, 4'b1111, "restart_w1");
    feed(model, W2, 4'b0001, "restart_w2");
    check_const(32'h340BC6D9, "restart_123456789");

    feed(32'h12345678, 32'hA5A5C3C3, 4'b0011, "explicit_seed");
    feed(model, 32'hDEADBEEF, 4'b0111, "three_lanes");
    feed(model, 32'hCAFEF00D, 4'b1011, "mask_1011");
    feed(model, 32'h0BADF00D, 4'b0101, "mask_0101");
    feed(32'h89ABCDEF, 32'h55AA55AA, 4'b1110, "mask_1110");
    feed(model, 32'h13579BDF, 4'b1000, "mask_1000");

    for (int s = 0; s < 20; s++) begin
      int nbytes;
      int left;
      logic [3:0] m;
      nbytes = $urandom_range(1, 64);
      do_reset("rand_reset");
      left = nbytes;
      while (left > 0) begin
        case (left)
          1:       m = 4'b0001;
          2:       m = 4'b0011;
          3:       m = 4'b0111;
          default: m = 4'b1111;
        endcase
        if ($urandom_range(0, 4) == 0) gap(1);
        feed(model, $urandom, m, "rand_word");
        left = (left > 4) ? left - 4 : 0;
      end
    end

    repeat (3) @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
